// File: rtl/aes256_rkey_reverse_buf_pkg.sv
// Shared constants and state encoding for the AES-256 reverse round-key buffer.
package aes256_rkey_reverse_buf_pkg;

    localparam int unsigned AES_NR    = 14;
    localparam int unsigned AES_NRK   = AES_NR + 1;
    localparam int unsigned AES_BLK_W = 128;
    localparam int unsigned AES_RND_W = 4;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_IDLE = 2'd1,
        ST_READ = 2'd2
    } rkey_state_e;

endpackage

// File: rtl/aes256_rkey_mem.sv
// Round-key register file: one synchronous write port, one asynchronous read port, no reset.
module aes256_rkey_mem #(
    parameter int unsigned DEPTH_P = 15,
    parameter int unsigned W_P     = 128,
    parameter int unsigned AW_P    = 4
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [AW_P-1:0] waddr_i,
    input  logic [W_P-1:0]  wdata_i,
    input  logic [AW_P-1:0] raddr_i,
    output logic [W_P-1:0]  rdata_o
);

    logic [W_P-1:0] mem_q [DEPTH_P];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Out-of-range addresses read as zero rather than undefined storage.
    assign rdata_o = (raddr_i < AW_P'(DEPTH_P)) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/aes256_rkey_reverse_buf.sv
// Stores the forward AES-256 key schedule and replays it rk14..rk0 per block for decryption.
module aes256_rkey_reverse_buf
    import aes256_rkey_reverse_buf_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS_P = AES_NR,
    parameter int unsigned KEY_W_P      = AES_BLK_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 wr_valid_i,
    input  logic [KEY_W_P-1:0]   wr_key_i,
    output logic                 wr_ready_o,
    output logic                 keys_valid_o,
    input  logic                 rd_start_i,
    output logic                 rd_valid_o,
    input  logic                 rd_ready_i,
    output logic [KEY_W_P-1:0]   rd_key_o,
    output logic [AES_RND_W-1:0] rd_round_o,
    output logic                 rd_done_o
);

    localparam int unsigned DEPTH = NUM_ROUNDS_P + 1;
    localparam int unsigned PTR_W = AES_RND_W;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_ROUNDS_P);

    rkey_state_e      state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             rd_done_q, rd_done_d;
    logic             wr_ready_q, keys_valid_q, rd_valid_q;
    logic             mem_we;
    logic [KEY_W_P-1:0] mem_rdata;

    // Next-state logic; flush overrides any handshake in the same cycle.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_done_d = 1'b0;
        mem_we    = 1'b0;
        if (flush_i) begin
            state_d  = ST_LOAD;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (wr_valid_i) begin
                        mem_we = 1'b1;
                        if (wr_ptr_q == LAST_PTR) begin
                            state_d = ST_IDLE;
                        end else begin
                            wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        end
                    end
                end
                ST_IDLE: begin
                    if (rd_start_i) begin
                        state_d  = ST_READ;
                        rd_ptr_d = LAST_PTR;
                    end
                end
                ST_READ: begin
                    if (rd_ready_i) begin
                        if (rd_ptr_q == '0) begin
                            state_d   = ST_IDLE;
                            rd_done_d = 1'b1;
                        end else begin
                            rd_ptr_d = rd_ptr_q - PTR_W'(1);
                        end
                    end
                end
                default: begin
                    state_d  = ST_LOAD;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end
            endcase
        end
    end

    // Status flags are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_LOAD;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_done_q    <= 1'b0;
            wr_ready_q   <= 1'b1;
            keys_valid_q <= 1'b0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_done_q    <= rd_done_d;
            wr_ready_q   <= (state_d == ST_LOAD);
            keys_valid_q <= (state_d != ST_LOAD);
            rd_valid_q   <= (state_d == ST_READ);
        end
    end

    aes256_rkey_mem #(
        .DEPTH_P (DEPTH),
        .W_P     (KEY_W_P),
        .AW_P    (PTR_W)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_key_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    assign wr_ready_o   = wr_ready_q;
    assign keys_valid_o = keys_valid_q;
    assign rd_valid_o   = rd_valid_q;
    assign rd_key_o     = rd_valid_q ? mem_rdata : '0;
    assign rd_round_o   = rd_ptr_q;
    assign rd_done_o    = rd_done_q;

endmodule
